// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator for 8-bit raster video.
// Two line buffers provide the two previous lines. A 3x3 tap array shifts
// left on every accepted pixel. A window is emitted one cycle after each pixel
// that completes a full in-frame neighbourhood (row >= 2 and col >= 2).
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_pixel,
  input  logic        in_sof,
  output logic        out_valid,
  output logic [71:0] window,
  output logic [11:0] out_row,
  output logic [11:0] out_col,
  output logic        frame_done
);

  localparam int          DATA_W   = 8;
  localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

  // Shift the tap array one column left and insert the new right column.
  // Byte 8 is the newest pixel and byte 0 the oldest top-left pixel.
  function automatic logic [71:0] shift_taps(input logic [71:0]       t,
                                             input logic [DATA_W-1:0] top,
                                             input logic [DATA_W-1:0] mid,
                                             input logic [DATA_W-1:0] bot);
    return {bot, t[71:64], t[63:56],
            mid, t[47:40], t[39:32],
            top, t[23:16], t[15:8]};
  endfunction

  // Position counters and the 3x3 tap array.
  logic [11:0]       row_q;
  logic [11:0]       col_q;
  logic [71:0]       taps;

  // Line buffers. lb1 holds the previous line and lb2 the line before that.
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];

  // Stage p0 (combinational): effective position of the incoming beat,
  // the line-buffer reads and the next tap contents.
  logic [11:0]       row_p0;
  logic [11:0]       col_p0;
  logic [11:0]       row_nx_p0;
  logic [11:0]       col_nx_p0;
  logic [AW-1:0]     idx_p0;
  logic [DATA_W-1:0] lb1_rd_p0;
  logic [DATA_W-1:0] lb2_rd_p0;
  logic [71:0]       taps_nx_p0;
  logic              vld_p0;
  logic              last_p0;

  // in_sof with a valid beat forces this pixel to (0,0) and drops the partial frame.
  assign row_p0     = in_sof ? 12'd0 : row_q;
  assign col_p0     = in_sof ? 12'd0 : col_q;
  assign idx_p0     = col_p0[AW-1:0];
  assign lb1_rd_p0  = lb1[idx_p0];
  assign lb2_rd_p0  = lb2[idx_p0];
  assign taps_nx_p0 = shift_taps(taps, lb2_rd_p0, lb1_rd_p0, in_pixel);

  // A window is complete only when all three columns come from the current line
  // and all three lines come from this frame. The row >= 2 gate also keeps stale
  // line-buffer data out of any asserted window.
  assign vld_p0  = in_valid && (row_p0 >= 12'd2) && (col_p0 >= 12'd2);
  assign last_p0 = in_valid && (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

  // Raster counter advance with line and frame wrap.
  always_comb begin
    row_nx_p0 = row_p0;
    col_nx_p0 = col_p0 + 12'd1;
    if (col_p0 == COL_LAST) begin
      col_nx_p0 = 12'd0;
      row_nx_p0 = (row_p0 == ROW_LAST) ? 12'd0 : row_p0 + 12'd1;
    end
  end

  // Position counters advance once per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= 12'd0;
      col_q <= 12'd0;
    end else if (in_valid) begin
      row_q <= row_nx_p0;
      col_q <= col_nx_p0;
    end
  end

  // Tap array shifts on every accepted beat, whether or not a window is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (in_valid) begin
      taps <= taps_nx_p0;
    end
  end

  // Line buffers: the current pixel goes into lb1 and the old lb1 entry moves to
  // lb2. These are plain RAM with no reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[idx_p0] <= in_pixel;
      lb2[idx_p0] <= lb1_rd_p0;
    end
  end

  // Stage p1: single-cycle valid and frame_done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= vld_p0;
      frame_done <= last_p0;
    end
  end

  // Stage p1: the window and its centre coordinates load only with a valid
  // window, so they hold their values between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window  <= '0;
      out_row <= 12'd0;
      out_col <= 12'd0;
    end else if (vld_p0) begin
      window  <= taps_nx_p0;
      out_row <= row_p0 - 12'd1;
      out_col <= col_p0 - 12'd1;
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed testbench for window_3x3_gen (4x4 image). A frame model computes the
// expected windows and queues them; DUT outputs are checked on the falling edge.
module tb_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = 8'd0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic [71:0] window;
  logic [11:0] out_row;
  logic [11:0] out_col;
  logic        frame_done;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .window     (window),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    logic [11:0] r;
    logic [11:0] c;
  } exp_t;

  exp_t        sbq[$];
  logic [71:0] obs_win[$];
  logic [7:0]  img [H][W];
  int          mr = 0;
  int          mc = 0;
  logic        exp_vld = 1'b0;
  logic        exp_done = 1'b0;
  int          pulse_cnt = 0;
  int          done_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [71:0] WIN_FIRST = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] WIN_WRAP  = 72'h32_31_30_22_21_20_12_11_10;
  localparam logic [71:0] WIN_B     = 72'hA2_A1_A0_92_91_90_82_81_80;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] get_obs(input int i);
    if (i < obs_win.size()) return obs_win[i];
    return 'x;
  endfunction

  // Check the outputs produced by the beat driven on the previous falling edge.
  task automatic check_outputs();
    exp_t e;
    chk("out_valid", {71'd0, out_valid}, {71'd0, exp_vld});
    chk("frame_done", {71'd0, frame_done}, {71'd0, exp_done});
    if (frame_done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) begin
      pulse_cnt++;
      obs_win.push_back(window);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("window", window, e.w);
        chk("out_row", {60'd0, out_row}, {60'd0, e.r});
        chk("out_col", {60'd0, out_col}, {60'd0, e.c});
      end else begin
        chk("extra_pulse", 72'd1, 72'd0);
      end
    end else if (exp_vld && sbq.size() > 0) begin
      void'(sbq.pop_front());
    end
  endtask

  // Reference model: track the raster position and the frame contents.
  task automatic model_update(input logic v, input logic [7:0] p, input logic s);
    exp_t e;
    exp_vld  = 1'b0;
    exp_done = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[8*(3*i+j) +: 8] = img[mr-2+i][mc-2+j];
        e.r = 12'(mr - 1);
        e.c = 12'(mc - 1);
        sbq.push_back(e);
        exp_vld = 1'b1;
      end
      exp_done = (mr == H-1) && (mc == W-1);
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] p, input logic s);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_pixel = p;
    in_sof   = s;
    model_update(v, p, s);
  endtask

  task automatic send_frame(input logic [7:0] base, input int gapmax, input logic sof0,
                            input int npix);
    for (int i = 0; i < npix; i++) begin
      tick(1'b1, base + 8'(16*(i/W) + (i%W)), sof0 && (i == 0));
      if (gapmax > 0)
        repeat ($urandom_range(0, gapmax)) tick(1'b0, 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic clear_stats();
    pulse_cnt = 0;
    done_cnt  = 0;
    obs_win.delete();
  endtask

  initial begin
    // Reset asserted asynchronously, before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
    chk("rst_window", window, 72'd0);
    chk("rst_out_row", {60'd0, out_row}, 72'd0);
    chk("rst_out_col", {60'd0, out_col}, 72'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Continuous frame.
    clear_stats();
    send_frame(8'h00, 0, 1'b0, W*H);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("cont_pulses", 72'(pulse_cnt), 72'd4);
    chk("cont_done", 72'(done_cnt), 72'd1);
    chk("cont_first_win", get_obs(0), WIN_FIRST);
    chk("cont_wrap_win", get_obs(2), WIN_WRAP);

    // Same frame with random gaps and in_sof noise while in_valid is low.
    clear_stats();
    send_frame(8'h00, 5, 1'b0, W*H);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("gap_pulses", 72'(pulse_cnt), 72'd4);
    chk("gap_done", 72'(done_cnt), 72'd1);
    chk("gap_first_win", get_obs(0), WIN_FIRST);
    chk("gap_wrap_win", get_obs(2), WIN_WRAP);

    // Frame A abandoned at (2,3) by in_sof, then full frame B.
    clear_stats();
    send_frame(8'h40, 0, 1'b1, 11);
    send_frame(8'h80, 2, 1'b1, W*H);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("sof_pulses", 72'(pulse_cnt), 72'd5);
    chk("sof_done", 72'(done_cnt), 72'd1);
    chk("sof_b_first_win", get_obs(1), WIN_B);

    // Reset in the middle of the cycle after pixel (2,2).
    clear_stats();
    send_frame(8'h00, 0, 1'b0, 11);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("pre_rst_valid", {71'd0, out_valid}, 72'd1);
    chk("pre_rst_window", window, WIN_FIRST);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {71'd0, out_valid}, 72'd0);
    chk("mid_rst_window", window, 72'd0);
    chk("mid_rst_out_row", {60'd0, out_row}, 72'd0);
    chk("mid_rst_out_col", {60'd0, out_col}, 72'd0);
    chk("mid_rst_frame_done", {71'd0, frame_done}, 72'd0);
    sbq.delete();
    exp_vld  = 1'b0;
    exp_done = 1'b0;
    mr = 0;
    mc = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    send_frame(8'h00, 0, 1'b0, W*H);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("post_rst_pulses", 72'(pulse_cnt), 72'd4);
    chk("post_rst_done", 72'(done_cnt), 72'd1);
    chk("post_rst_first_win", get_obs(0), WIN_FIRST);

    // Two back-to-back frames with no in_sof.
    clear_stats();
    send_frame(8'h00, 0, 1'b0, W*H);
    send_frame(8'h00, 0, 1'b0, W*H);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("b2b_pulses", 72'(pulse_cnt), 72'd8);
    chk("b2b_done", 72'(done_cnt), 72'd2);
    chk("b2b_second_first_win", get_obs(4), WIN_FIRST);
    chk("sb_empty", 72'(sbq.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
